apb_req_master: RTL and testbench



---
 rtl/apb_req_master_pkg.sv | 14 +
 rtl/apb_req_master_timeout.sv | 37 +++
 rtl/apb_req_master.sv | 141 ++++++++++++++
 tb/tb_apb_req_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_master_pkg.sv
// Shared types and constants for the request/grant to APB master bridge.
package apb_req_master_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} apb_mst_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1A10_0000;
    localparam logic [31:0] DEF_END_ADDR  = 32'h1A11_7FFF;

    // $clog2(cycles+1), floored at one bit so a disabled timeout still has a legal width.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_req_master_timeout.sv
// ACCESS-phase wait counter: flags the last permitted cycle without pready.
module apb_req_master_timeout
    import apb_req_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_cnt
            localparam int unsigned   CW   = tmo_cnt_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expired = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_req_master.sv
// Single-word request/grant to APB master bridge with address-window check and pready timeout.
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = ADDR_WIDTH'(DEF_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0]  END_ADDR       = ADDR_WIDTH'(DEF_END_ADDR),
    parameter int unsigned            TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    apb_mst_state_e state, next_state;

    logic win_ok;
    logic accept;
    logic done_ok;
    logic done_to;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    assign win_ok = (addr_i >= BASE_ADDR) && (addr_i <= END_ADDR);

    apb_req_master_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        gnt_o      = 1'b0;
        psel_o     = 1'b0;
        penable_o  = 1'b0;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        case (state)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    accept     = 1'b1;
                    next_state = win_ok ? SETUP : DERR;
                end
            end
            SETUP: begin
                psel_o     = 1'b1;
                tmo_clr    = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                tmo_en    = !pready_i;
                // pready takes priority over an expiring counter in the same cycle
                if (pready_i) begin
                    done_ok    = 1'b1;
                    next_state = IDLE;
                end else if (tmo_expired) begin
                    done_to    = 1'b1;
                    next_state = IDLE;
                end
            end
            DERR: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The out-of-window response is registered at grant so it lines up with the DERR cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            if (accept) begin
                paddr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                pwdata_o <= wdata_i;
                pwrite_o <= we_i;
                if (!win_ok) begin
                    rvalid_o <= 1'b1;
                    err_o    <= 1'b1;
                    rdata_o  <= '0;
                end
            end
            if (done_ok) begin
                rvalid_o <= 1'b1;
                err_o    <= pslverr_i;
                rdata_o  <= pwrite_o ? '0 : prdata_i;
            end
            if (done_to) begin
                rvalid_o <= 1'b1;
                err_o    <= 1'b1;
                rdata_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Scenario bench for apb_req_master: expected responses queued at issue, popped on rvalid.
module tb_apb_req_master;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    apb_req_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (32'h1A10_0000),
        .END_ADDR      (32'h1A11_7FFF),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .paddr_o  (paddr_o),
        .pwdata_o (pwdata_o),
        .pwrite_o (pwrite_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .prdata_i (prdata_i),
        .pready_i (pready_i),
        .pslverr_i(pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic wait_rsp(input int budget, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            req_i = 1'b0;
            #1;
            lat++;
            got = rvalid_o;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o});
        end
        total++;
        if ({paddr_o, pwdata_o, rdata_o} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", paddr_o, pwdata_o, rdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        rsp_t e;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_3004; we_i = 1'b0; wdata_i = 32'h0;
        pready_i = 1'b1; prdata_i = 32'h1234_5678; pslverr_i = 1'b0;
        #1;
        total++;
        if (gnt_o !== 1'b1) begin bad++; $display("FAIL read_gnt: got %b want 1", gnt_o); end
        exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        @(negedge clk); req_i = 1'b0; #1;
        total++;
        if ({psel_o, penable_o, pwrite_o} !== 3'b100 || paddr_o !== 32'h1A10_3004) begin
            bad++;
            $display("FAIL read_setup: psel/pen/pwrite=%b paddr=%h want 100 1a103004",
                     {psel_o, penable_o, pwrite_o}, paddr_o);
        end
        @(negedge clk); #1;
        total++;
        if ({psel_o, penable_o, rvalid_o} !== 3'b110) begin
            bad++;
            $display("FAIL read_access: psel/pen/rvalid=%b want 110", {psel_o, penable_o, rvalid_o});
        end
        @(negedge clk); pready_i = 1'b0; #1;
        total++;
        e = exp_q.pop_front();
        if (rvalid_o !== 1'b1 || rdata_o !== e.rdata || err_o !== e.err || psel_o !== 1'b0) begin
            bad++;
            $display("FAIL read_rsp: rvalid=%b rdata=%h err=%b psel=%b want 1 %h %b 0",
                     rvalid_o, rdata_o, err_o, psel_o, e.rdata, e.err);
        end
        @(negedge clk); #1;
        total++;
        if (rvalid_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL read_hold: rvalid=%b err=%b rdata=%h want 0 0 12345678", rvalid_o, err_o, rdata_o);
        end
    endtask

    task automatic test_write_wait();
        rsp_t e;
        int   stable_bad;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_1002; we_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
        pready_i = 1'b0; prdata_i = 32'hDEAD_BEEF;
        #1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge clk); req_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; we_i = 1'b0; #1;
        total++;
        if ({psel_o, penable_o, pwrite_o} !== 3'b101 || paddr_o !== 32'h1A10_1000 || pwdata_o !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL write_setup: ctl=%b paddr=%h pwdata=%h want 101 1a101000 a5a5a5a5",
                     {psel_o, penable_o, pwrite_o}, paddr_o, pwdata_o);
        end
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pready_i = (i == 4); #1;
            if ({psel_o, penable_o, pwrite_o, rvalid_o} !== 4'b1110 ||
                paddr_o !== 32'h1A10_1000 || pwdata_o !== 32'hA5A5_A5A5) stable_bad++;
        end
        total++;
        if (stable_bad != 0) begin
            bad++;
            $display("FAIL write_access_stable: %0d unstable ACCESS cycles, want 0", stable_bad);
        end
        @(negedge clk); pready_i = 1'b0; #1;
        total++;
        e = exp_q.pop_front();
        if (rvalid_o !== 1'b1 || rdata_o !== e.rdata || err_o !== e.err) begin
            bad++;
            $display("FAIL write_rsp_cycle7: rvalid=%b rdata=%h err=%b want 1 %h %b",
                     rvalid_o, rdata_o, err_o, e.rdata, e.err);
        end
    endtask

    task automatic test_window();
        logic [31:0] addrs [4];
        bit          inwin [4];
        rsp_t        e;
        int          lat;
        bit          got;
        bit          saw_psel;
        addrs[0] = 32'h1A0F_FFFC; inwin[0] = 1'b0;
        addrs[1] = 32'h1A10_0000; inwin[1] = 1'b1;
        addrs[2] = 32'h1A11_7FFF; inwin[2] = 1'b1;
        addrs[3] = 32'h1A20_0000; inwin[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_i = 1'b1; addr_i = addrs[i]; we_i = 1'b0;
            pready_i = 1'b1; prdata_i = 32'h5500_0000 + 32'(i);
            #1;
            exp_q.push_back(inwin[i] ? '{rdata: 32'h5500_0000 + 32'(i), err: 1'b0}
                                     : '{rdata: 32'h0, err: 1'b1});
            saw_psel = 1'b0;
            lat = 0; got = 1'b0;
            while (!got && lat < 10) begin
                @(negedge clk); req_i = 1'b0; #1;
                lat++;
                if (psel_o) saw_psel = 1'b1;
                got = rvalid_o;
            end
            total++;
            e = exp_q.pop_front();
            if (!got || lat != (inwin[i] ? 3 : 1) || rdata_o !== e.rdata || err_o !== e.err ||
                saw_psel !== inwin[i] || paddr_o !== {addrs[i][31:2], 2'b00}) begin
                bad++;
                $display("FAIL window_%0d: got=%0d lat=%0d rdata=%h err=%b psel_seen=%b paddr=%h want 1 %0d %h %b %b %h",
                         i, got, lat, rdata_o, err_o, saw_psel, paddr_o,
                         inwin[i] ? 3 : 1, e.rdata, e.err, inwin[i], {addrs[i][31:2], 2'b00});
            end
        end
        pready_i = 1'b0;
    endtask

    task automatic test_timeout();
        rsp_t e;
        int   acc;
        int   cyc;
        bit   got;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_0040; we_i = 1'b0;
        pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
        #1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        acc = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 30) begin
            @(negedge clk); req_i = 1'b0; #1;
            cyc++;
            if (psel_o && penable_o) acc++;
            got = rvalid_o;
        end
        total++;
        if (acc != 8) begin bad++; $display("FAIL timeout_access_cycles: got %0d want 8", acc); end
        total++;
        e = exp_q.pop_front();
        if (!got || cyc != 10 || rdata_o !== e.rdata || err_o !== e.err || psel_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_rsp: got=%0d cycle=%0d rdata=%h err=%b psel=%b want 1 10 %h %b 0",
                     got, cyc, rdata_o, err_o, psel_o, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_0010; we_i = 1'b1; wdata_i = 32'h0BAD_0001;
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h7777_7777;
        #1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge clk); addr_i = 32'h1A10_0020; we_i = 1'b0; wdata_i = 32'h0; #1;
        total++;
        if (gnt_o !== 1'b0) begin bad++; $display("FAIL b2b_no_gnt_setup: got %b want 0", gnt_o); end
        @(negedge clk); #1;
        total++;
        if (paddr_o !== 32'h1A10_0010 || pwrite_o !== 1'b1 || penable_o !== 1'b1 || gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_access: paddr=%h pwrite=%b penable=%b gnt=%b want 1a100010 1 1 0",
                     paddr_o, pwrite_o, penable_o, gnt_o);
        end
        @(negedge clk); pslverr_i = 1'b0; prdata_i = 32'hCAFE_F00D; #1;
        total++;
        e = exp_q.pop_front();
        if (rvalid_o !== 1'b1 || err_o !== e.err || rdata_o !== e.rdata || gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_slverr_rsp: rvalid=%b err=%b rdata=%h gnt=%b want 1 %b %h 1",
                     rvalid_o, err_o, rdata_o, gnt_o, e.err, e.rdata);
        end
        exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        @(negedge clk); req_i = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++;
        e = exp_q.pop_front();
        if (rvalid_o !== 1'b1 || err_o !== e.err || rdata_o !== e.rdata || paddr_o !== 32'h1A10_0020) begin
            bad++;
            $display("FAIL b2b_second_rsp: rvalid=%b err=%b rdata=%h paddr=%h want 1 %b %h 1a100020",
                     rvalid_o, err_o, rdata_o, paddr_o, e.err, e.rdata);
        end
        pready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        int   lat;
        bit   got;
        int   stray;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_0100; we_i = 1'b0; pready_i = 1'b0;
        #1;
        @(negedge clk); req_i = 1'b0; #1;
        @(negedge clk); #1;
        total++;
        if (penable_o !== 1'b1) begin bad++; $display("FAIL rstmid_in_access: penable=%b want 1", penable_o); end
        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; pready_i = 1'b1; prdata_i = 32'h0102_0304; #1;
        total++;
        if ({psel_o, penable_o, rvalid_o} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_abort: psel/pen/rvalid=%b want 000", {psel_o, penable_o, rvalid_o});
        end
        stray = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (rvalid_o || psel_o) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL rstmid_no_rsp: %0d stray cycles want 0", stray); end
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h1A10_0200; we_i = 1'b0;
        #1;
        exp_q.push_back('{rdata: 32'h0102_0304, err: 1'b0});
        wait_rsp(10, lat, got);
        total++;
        e = exp_q.pop_front();
        if (!got || lat != 3 || rdata_o !== e.rdata || err_o !== e.err) begin
            bad++;
            $display("FAIL rstmid_next_read: got=%0d lat=%0d rdata=%h err=%b want 1 3 %h %b",
                     got, lat, rdata_o, err_o, e.rdata, e.err);
        end
        pready_i = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_window();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
